// File: rtl/axi_full_slave_mem.sv
// Memory-backed AXI4 slave: independent single-outstanding read and write engines,
// INCR bursts of 64-bit beats into a DEPTH-word register array.
module axi_full_slave_mem #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        AWID,
    input  logic [31:0] AWADDR,
    input  logic [7:0]  AWLEN,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [63:0] WDATA,
    input  logic [7:0]  WSTRB,
    input  logic        WLAST,
    input  logic        WVALID,
    output logic        WREADY,
    output logic        BID,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic        ARID,
    input  logic [31:0] ARADDR,
    input  logic [7:0]  ARLEN,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic        RID,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        RVALID,
    input  logic        RREADY
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [63:0]      mem [DEPTH];
    w_state_t         w_state, w_state_nxt;
    r_state_t         r_state, r_state_nxt;
    logic [IDX_W-1:0] w_idx, r_idx, ar_idx;
    logic [7:0]       w_cnt, r_cnt;
    logic             w_err;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic             w_final, w_beat_err;

    // Sub-word and above-array address bits carry no meaning for this memory
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[31:3+IDX_W], AWADDR[2:0],
                                ARADDR[31:3+IDX_W], ARADDR[2:0]};

    assign aw_hs      = AWVALID && AWREADY;
    assign w_hs       = WVALID && WREADY;
    assign b_hs       = BVALID && BREADY;
    assign ar_hs      = ARVALID && ARREADY;
    assign r_hs       = RVALID && RREADY;
    assign ar_idx     = ARADDR[3 +: IDX_W];
    assign w_final    = (w_cnt == 8'd0);
    assign w_beat_err = (WLAST != w_final);
    assign RRESP      = 2'b00;

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && RLAST) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Write engine and memory array; a WLAST mismatch on any beat makes the burst SLVERR
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= 1'b0;
            BRESP   <= 2'b00;
            w_idx   <= '0;
            w_cnt   <= 8'd0;
            w_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
        end else begin
            w_state <= w_state_nxt;
            AWREADY <= (w_state_nxt == W_IDLE);
            WREADY  <= (w_state_nxt == W_DATA);
            BVALID  <= (w_state_nxt == W_RESP);
            if (aw_hs) begin
                BID   <= AWID;
                w_idx <= AWADDR[3 +: IDX_W];
                w_cnt <= AWLEN;
                w_err <= 1'b0;
            end
            if (w_hs) begin
                for (int b = 0; b < 8; b++) begin
                    if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
                end
                w_idx <= w_idx + IDX_W'(1);
                w_cnt <= w_cnt - 8'd1;
                w_err <= w_err | w_beat_err;
                if (w_final) BRESP <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
            end
            if (b_hs) BRESP <= 2'b00;
        end
    end

    // Read engine: next word is prefetched on each handshake so beats stream back-to-back
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RID     <= 1'b0;
            RDATA   <= 64'd0;
            RLAST   <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= r_state_nxt;
            ARREADY <= (r_state_nxt == R_IDLE);
            RVALID  <= (r_state_nxt == R_DATA);
            if (ar_hs) begin
                RID   <= ARID;
                RDATA <= mem[ar_idx];
                RLAST <= (ARLEN == 8'd0);
                r_idx <= ar_idx + IDX_W'(1);
                r_cnt <= ARLEN;
            end else if (r_hs) begin
                if (RLAST) begin
                    RLAST <= 1'b0;
                end else begin
                    RDATA <= mem[r_idx];
                    RLAST <= (r_cnt == 8'd1);
                    r_idx <= r_idx + IDX_W'(1);
                    r_cnt <= r_cnt - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_full_slave_mem.sv
// Directed bench for axi_full_slave_mem: bursts, strobes, wrap, backpressure,
// WLAST protocol errors and mid-burst reset.
module tb_axi_full_slave_mem;

    logic        ACLK, ARESETn;
    logic        AWID, AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic        BID, BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARID, ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        RID, RLAST, RVALID, RREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;

    int checks = 0;
    int errors = 0;
    logic [63:0] wd [32];
    logic [63:0] exp_d [32];

    axi_full_slave_mem #(.DEPTH(64)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, 64'(AWREADY), 64'd0);
        check({tag, "_wready"},  64'(WREADY),  64'd0);
        check({tag, "_bvalid"},  64'(BVALID),  64'd0);
        check({tag, "_bresp"},   64'(BRESP),   64'd0);
        check({tag, "_arready"}, 64'(ARREADY), 64'd0);
        check({tag, "_rvalid"},  64'(RVALID),  64'd0);
        check({tag, "_rlast"},   64'(RLAST),   64'd0);
        check({tag, "_rdata"},   RDATA,        64'd0);
    endtask

    // Write burst using wd[]; WLAST asserted on beat last_beat only
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] strb,
                               input int last_beat, input logic id, input int bdelay,
                               input logic [1:0] exp_resp);
        int cyc;
        @(negedge ACLK);
        AWADDR = addr; AWLEN = len; AWID = id; AWVALID = 1'b1;
        cyc = 0;
        while (!AWREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
        if (cyc >= 50) check("aw_timeout", 64'(AWREADY), 64'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        check("awready_busy", 64'(AWREADY), 64'd0);
        for (int k = 0; k <= int'(len); k++) begin
            WDATA = wd[k]; WSTRB = strb; WLAST = (k == last_beat); WVALID = 1'b1;
            check("wready", 64'(WREADY), 64'd1);
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("wready_done", 64'(WREADY), 64'd0);
        check("bvalid",      64'(BVALID), 64'd1);
        check("bresp",       64'(BRESP),  64'(exp_resp));
        check("bid",         64'(BID),    64'(id));
        for (int i = 0; i < bdelay; i++) begin
            @(negedge ACLK);
            check("bvalid_hold", 64'(BVALID), 64'd1);
            check("bresp_hold",  64'(BRESP),  64'(exp_resp));
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("bvalid_clear", 64'(BVALID),  64'd0);
        check("awready_back", 64'(AWREADY), 64'd1);
    endtask

    // Read burst checked against exp_d[]; bp applies RREADY pattern 1,0,0,1;
    // returns early with beat stop_at presented but not accepted
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic id,
                              input bit bp, input int stop_at);
        int n, cyc;
        logic [63:0] sd;
        logic sl, stalled;
        @(negedge ACLK);
        ARADDR = addr; ARLEN = len; ARID = id; ARVALID = 1'b1;
        cyc = 0;
        while (!ARREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
        if (cyc >= 50) check("ar_timeout", 64'(ARREADY), 64'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("rvalid_first", 64'(RVALID), 64'd1);
        n = 0; cyc = 0; stalled = 1'b0; sd = '0; sl = 1'b0;
        while (n <= int'(len) && n != stop_at && cyc < 300) begin
            if (stalled) begin
                check("rdata_hold", RDATA, sd);
                check("rlast_hold", 64'(RLAST), 64'(sl));
            end
            RREADY = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (RVALID && RREADY) begin
                check($sformatf("rdata_%0d", n), RDATA, exp_d[n]);
                check($sformatf("rlast_%0d", n), 64'(RLAST), 64'(n == int'(len)));
                check("rid", 64'(RID), 64'(id));
                n++;
                stalled = 1'b0;
            end else if (RVALID) begin
                stalled = 1'b1; sd = RDATA; sl = RLAST;
            end else begin
                check("rvalid_burst", 64'(RVALID), 64'd1);
            end
            @(negedge ACLK);
            cyc++;
        end
        if (n != stop_at) begin
            RREADY = 1'b0;
            check("r_beats", 64'(n), 64'(int'(len) + 1));
            check("rvalid_end",  64'(RVALID),  64'd0);
            check("arready_end", 64'(ARREADY), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWVALID = 0;
        WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
        ARID = 0; ARADDR = 0; ARLEN = 0; ARVALID = 0; RREADY = 0;
        repeat (3) @(negedge ACLK);
        check_outputs_zero("reset");
        ARESETn = 1'b1;
        @(negedge ACLK);

        // 32-beat burst at 0: data k+1
        for (int k = 0; k < 32; k++) begin wd[k] = 64'(k + 1); exp_d[k] = 64'(k + 1); end
        write_burst(32'h0, 8'd31, 8'hFF, 31, 1'b1, 0, 2'b00);
        read_burst(32'h0, 8'd31, 1'b1, 1'b0, -1);

        // Partial strobe into word 2 after clearing it
        wd[0] = 64'd0;
        write_burst(32'h10, 8'd0, 8'hFF, 0, 1'b0, 0, 2'b00);
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        write_burst(32'h10, 8'd0, 8'h0F, 0, 1'b0, 0, 2'b00);
        exp_d[0] = 64'h0000_0000_FFFF_FFFF;
        read_burst(32'h10, 8'd0, 1'b0, 1'b0, -1);

        // Wrap from index 62 through 1, with BREADY held low 5 cycles
        for (int k = 0; k < 4; k++) wd[k] = 64'hA0 + 64'(k);
        write_burst(32'h1F0, 8'd3, 8'hFF, 3, 1'b1, 5, 2'b00);
        for (int k = 0; k < 4; k++) exp_d[k] = 64'hA0 + 64'(k);
        exp_d[4] = 64'h0000_0000_FFFF_FFFF;
        read_burst(32'h1F0, 8'd4, 1'b0, 1'b0, -1);

        // Backpressured full read of words 0..31
        exp_d[0] = 64'hA2;
        exp_d[1] = 64'hA3;
        exp_d[2] = 64'h0000_0000_FFFF_FFFF;
        for (int k = 3; k < 32; k++) exp_d[k] = 64'(k + 1);
        read_burst(32'h0, 8'd31, 1'b1, 1'b1, -1);

        // Early WLAST on beat 2 of 4, then WLAST missing entirely
        for (int k = 0; k < 4; k++) wd[k] = 64'hB0 + 64'(k);
        write_burst(32'h100, 8'd3, 8'hFF, 2, 1'b0, 0, 2'b10);
        write_burst(32'h140, 8'd1, 8'hFF, 99, 1'b1, 0, 2'b10);
        for (int k = 0; k < 4; k++) exp_d[k] = 64'hB0 + 64'(k);
        read_burst(32'h100, 8'd3, 1'b0, 1'b0, -1);

        // Reset while beat 10 of a read is presented
        exp_d[0] = 64'hA2;
        exp_d[1] = 64'hA3;
        exp_d[2] = 64'h0000_0000_FFFF_FFFF;
        for (int k = 3; k < 32; k++) exp_d[k] = 64'(k + 1);
        read_burst(32'h0, 8'd31, 1'b1, 1'b0, 10);
        ARESETn = 1'b0;
        RREADY = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        for (int k = 0; k < 32; k++) exp_d[k] = 64'd0;
        read_burst(32'h0, 8'd31, 1'b0, 1'b0, -1);
        read_burst(32'h1F0, 8'd3, 1'b1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
